// File: rtl/la_pkg.sv
// Shared types for the logic-analyser capture engine:
// trigger conditions, combine modes and capture FSM states.
package la_pkg;

  typedef enum logic [2:0] {
    COND_LOW  = 3'b000,
    COND_HIGH = 3'b001,
    COND_FALL = 3'b010,
    COND_RISE = 3'b011,
    COND_ANY  = 3'b100
  } la_cond_e;

  typedef enum logic [1:0] {
    MODE_AND  = 2'b00,
    MODE_OR   = 2'b01,
    MODE_NAND = 2'b10,
    MODE_NOR  = 2'b11
  } la_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_ARMED,
    ST_POST,
    ST_DONE
  } la_state_e;

endpackage

// File: rtl/la_sample_ram.sv
// Sample buffer: simple dual-port RAM, one write port, registered read.
// Ports: clk_i/rst_i, we_i/waddr_i/wdata_i, re_i/raddr_i, rdata_o.
module la_sample_ram #(
  parameter int W  = 8,
  parameter int AW = 12
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [2**AW];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Only the output register is reset; contents survive rst.
  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/la_capture_core.sv
// Logic-analyser capture engine: synchroniser, divider, trigger, ring buffer.
// Ports: cfg_* run control, status_* state, rd_* post-capture readout.
module la_capture_core
  import la_pkg::*;
#(
  parameter int CH_NUM     = 8,
  parameter int DEPTH_LOG2 = 12,
  parameter int DIV_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH_NUM-1:0]     digital_in,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic [1:0]            cfg_mode,
  input  logic [3*CH_NUM-1:0]   cfg_cond,
  input  logic [DEPTH_LOG2-1:0] cfg_pre,
  input  logic [DIV_W-1:0]      cfg_div,
  output logic                  status_busy,
  output logic                  status_triggered,
  output logic                  status_done,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [CH_NUM-1:0]     rd_data,
  output logic                  rd_valid
);

  localparam int AW = DEPTH_LOG2;

  la_state_e            state_q, state_d;
  la_mode_e             mode_q, mode_d;
  logic [3*CH_NUM-1:0]  cond_q, cond_d;
  logic [AW-1:0]        pre_q, pre_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        pre_cnt_q, pre_cnt_d;
  logic [AW-1:0]        post_cnt_q, post_cnt_d;
  logic [AW-1:0]        trig_ptr_q, trig_ptr_d;
  logic                 trig_q, trig_d;
  logic                 first_q, first_d;
  logic [CH_NUM-1:0]    prev_q, prev_d;
  logic [CH_NUM-1:0]    sync1_q, sync2_q;
  logic                 rd_valid_q;
  logic                 busy, tick, we, hit, start_ok;

  function automatic logic trig_eval(
    input logic [3*CH_NUM-1:0] cond,
    input la_mode_e            mode,
    input logic [CH_NUM-1:0]   cur,
    input logic [CH_NUM-1:0]   prev,
    input logic                first
  );
    logic all_m, any_m, m, used;
    all_m = 1'b1;
    any_m = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      m    = 1'b0;
      used = 1'b1;
      case (la_cond_e'(cond[3*i+:3]))
        COND_LOW:  m = ~cur[i];
        COND_HIGH: m = cur[i];
        COND_FALL: m = ~first & prev[i] & ~cur[i];
        COND_RISE: m = ~first & ~prev[i] & cur[i];
        COND_ANY:  m = ~first & (prev[i] ^ cur[i]);
        default:   used = 1'b0;
      endcase
      if (used) begin
        all_m = all_m & m;
        any_m = any_m | m;
      end
    end
    case (mode)
      MODE_AND:  return all_m;
      MODE_OR:   return any_m;
      MODE_NAND: return ~all_m;
      default:   return ~any_m;
    endcase
  endfunction

  assign busy     = (state_q == ST_PRE) || (state_q == ST_ARMED)
                 || (state_q == ST_POST);
  assign tick     = busy && (cnt_q == div_q);
  assign start_ok = cfg_start && !cfg_stop && !busy;
  assign hit      = trig_eval(cond_q, mode_q, sync2_q, prev_q, first_q);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cond_d     = cond_q;
    pre_d      = pre_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    pre_cnt_d  = pre_cnt_q;
    post_cnt_d = post_cnt_q;
    trig_ptr_d = trig_ptr_q;
    trig_d     = trig_q;
    first_d    = first_q;
    prev_d     = prev_q;
    we         = 1'b0;
    if (busy) cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          // cfg_pre port width already bounds it to DEPTH-1
          mode_d    = la_mode_e'(cfg_mode);
          cond_d    = cfg_cond;
          pre_d     = cfg_pre;
          div_d     = cfg_div;
          cnt_d     = '0;
          wr_ptr_d  = '0;
          pre_cnt_d = '0;
          trig_d    = 1'b0;
          first_d   = 1'b1;
          state_d   = ST_PRE;
        end
      end
      ST_PRE: begin
        if (pre_q == '0) begin
          state_d = ST_ARMED;
        end else if (tick) begin
          we        = 1'b1;
          pre_cnt_d = pre_cnt_q + AW'(1);
          if (pre_cnt_d == pre_q) state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (tick) begin
          we = 1'b1;
          if (hit) begin
            trig_ptr_d = wr_ptr_q;
            trig_d     = 1'b1;
            // DEPTH-1-pre in AW bits is the bitwise inverse
            post_cnt_d = ~pre_q;
            state_d    = (~pre_q == '0) ? ST_DONE : ST_POST;
          end
        end
      end
      ST_POST: begin
        if (tick) begin
          we         = 1'b1;
          post_cnt_d = post_cnt_q - AW'(1);
          if (post_cnt_q == AW'(1)) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (busy && cfg_stop) begin
      state_d = ST_IDLE;
      trig_d  = trig_q;
      we      = 1'b0;
    end
    if (we) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      prev_d   = sync2_q;
      first_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_AND;
      cond_q     <= '0;
      pre_q      <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      pre_cnt_q  <= '0;
      post_cnt_q <= '0;
      trig_ptr_q <= '0;
      trig_q     <= 1'b0;
      first_q    <= 1'b0;
      prev_q     <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cond_q     <= cond_d;
      pre_q      <= pre_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      pre_cnt_q  <= pre_cnt_d;
      post_cnt_q <= post_cnt_d;
      trig_ptr_q <= trig_ptr_d;
      trig_q     <= trig_d;
      first_q    <= first_d;
      prev_q     <= prev_d;
      sync1_q    <= digital_in;
      sync2_q    <= sync1_q;
      rd_valid_q <= rd_en;
    end
  end

  la_sample_ram #(
    .W  (CH_NUM),
    .AW (AW)
  ) u_ram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (sync2_q),
    .re_i    (rd_en),
    .raddr_i (trig_ptr_q - pre_q + rd_addr),
    .rdata_o (rd_data)
  );

  assign status_busy      = busy;
  assign status_triggered = trig_q;
  assign status_done      = (state_q == ST_DONE);
  assign rd_valid         = rd_valid_q;

endmodule

// File: tb/tb_la_capture_core.sv
// Directed bench for la_capture_core with DEPTH=16, CH_NUM=8.
// Covers timing, divider, combine modes, pre-trigger edges, stop, reset.
module tb_la_capture_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  digital_in;
  logic        cfg_start, cfg_stop;
  logic [1:0]  cfg_mode;
  logic [23:0] cfg_cond;
  logic [3:0]  cfg_pre;
  logic [15:0] cfg_div;
  logic        status_busy, status_triggered, status_done;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        rd_valid;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int c0    = 0;

  localparam logic [23:0] C_DC    = 24'hFFFFFF;
  localparam logic [23:0] C_RISE1 = 24'hFFFFDF;
  localparam logic [23:0] C_HIGH0 = 24'hFFFFF9;
  localparam logic [23:0] C_H0F2  = 24'hFFFEB9;

  la_capture_core #(
    .CH_NUM     (8),
    .DEPTH_LOG2 (4),
    .DIV_W      (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .digital_in       (digital_in),
    .cfg_start        (cfg_start),
    .cfg_stop         (cfg_stop),
    .cfg_mode         (cfg_mode),
    .cfg_cond         (cfg_cond),
    .cfg_pre          (cfg_pre),
    .cfg_div          (cfg_div),
    .status_busy      (status_busy),
    .status_triggered (status_triggered),
    .status_done      (status_done),
    .rd_en            (rd_en),
    .rd_addr          (rd_addr),
    .rd_data          (rd_data),
    .rd_valid         (rd_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [1:0] m, input logic [23:0] c,
                           input logic [3:0] p, input logic [15:0] d);
    cfg_mode  = m;
    cfg_cond  = c;
    cfg_pre   = p;
    cfg_div   = d;
    cfg_start = 1'b1;
    tick_n(1);
    cfg_start = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    int n = 0;
    while (!status_done && n < 500) begin
      tick_n(1);
      n++;
    end
    check(tag, cyc - c0, exp_cyc);
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a,
                        input logic [7:0] exp);
    rd_addr = a;
    rd_en   = 1'b1;
    tick_n(1);
    rd_en   = 1'b0;
    check(tag, {23'd0, rd_valid, rd_data}, {23'd0, 1'b1, exp});
  endtask

  initial begin
    rst        = 1'b1;
    digital_in = 8'h80;
    cfg_start  = 1'b0;
    cfg_stop   = 1'b0;
    cfg_mode   = 2'b00;
    cfg_cond   = C_DC;
    cfg_pre    = 4'd0;
    cfg_div    = 16'd0;
    rd_en      = 1'b0;
    rd_addr    = 4'd0;
    tick_n(3);
    check("rst_busy", status_busy, 0);
    check("rst_trig", status_triggered, 0);
    check("rst_done", status_done, 0);
    check("rst_rd", {rd_valid, rd_data}, 0);
    rst = 1'b0;
    tick_n(1);

    // ch1 rising on tick 10, div 0
    start_run(2'b00, C_RISE1, 4'd4, 16'd0);
    tick_n(7);
    digital_in = 8'h82;
    wait_done("t1_done_cyc", 21);
    check("t1_trig", status_triggered, 1);
    check("t1_busy", status_busy, 0);
    rd_chk("t1_rd4", 4'd4, 8'h82);
    rd_chk("t1_rd3", 4'd3, 8'h80);
    rd_chk("t1_rd0", 4'd0, 8'h80);

    // same with div 3: 4x slower
    digital_in = 8'h80;
    tick_n(3);
    start_run(2'b00, C_RISE1, 4'd4, 16'd3);
    tick_n(37);
    digital_in = 8'h82;
    wait_done("t2_done_cyc", 84);
    rd_chk("t2_rd4", 4'd4, 8'h82);
    rd_chk("t2_rd3", 4'd3, 8'h80);
    rd_chk("t2_rd5", 4'd5, 8'h82);

    // all don't-care: AND fires at once, OR never
    digital_in = 8'h80;
    start_run(2'b00, C_DC, 4'd4, 16'd0);
    wait_done("t3_and_cyc", 16);
    check("t3_and_trig", status_triggered, 1);
    start_run(2'b01, C_DC, 4'd4, 16'd0);
    check("t3_or_trigclr", status_triggered, 0);
    tick_n(40);
    check("t3_or_busy", status_busy, 1);
    check("t3_or_trig", status_triggered, 0);
    cfg_stop = 1'b1;
    tick_n(1);
    cfg_stop = 1'b0;
    check("t3_stop_busy", status_busy, 0);
    check("t3_stop_done", status_done, 0);
    cfg_start = 1'b1;
    cfg_stop  = 1'b1;
    tick_n(1);
    cfg_start = 1'b0;
    cfg_stop  = 1'b0;
    check("t3_ss_busy", status_busy, 0);

    // pre 0, immediate hit
    digital_in = 8'h01;
    tick_n(3);
    start_run(2'b00, C_HIGH0, 4'd0, 16'd0);
    tick_n(2);
    digital_in = 8'h03;
    wait_done("t4a_done_cyc", 17);
    rd_chk("t4a_rd0", 4'd0, 8'h01);
    rd_chk("t4a_rd2", 4'd2, 8'h01);
    rd_chk("t4a_rd3", 4'd3, 8'h03);
    rd_chk("t4a_rd15", 4'd15, 8'h03);

    // pre 15, done on hit tick; PRE ignores trigger
    digital_in = 8'h00;
    tick_n(3);
    start_run(2'b00, C_HIGH0, 4'd15, 16'd0);
    tick_n(5);
    digital_in = 8'h01;
    wait_done("t4b_done_cyc", 16);
    rd_chk("t4b_rd15", 4'd15, 8'h01);
    rd_chk("t4b_rd0", 4'd0, 8'h00);
    rd_chk("t4b_rd6", 4'd6, 8'h00);
    rd_chk("t4b_rd7", 4'd7, 8'h01);

    // OR: ch2 falls with ch0 low
    digital_in = 8'h04;
    tick_n(3);
    start_run(2'b01, C_H0F2, 4'd2, 16'd0);
    tick_n(5);
    digital_in = 8'h00;
    wait_done("t5a_done_cyc", 21);
    rd_chk("t5a_rd2", 4'd2, 8'h00);
    rd_chk("t5a_rd1", 4'd1, 8'h04);

    // AND: needs ch0 high together with the fall
    digital_in = 8'h04;
    tick_n(3);
    start_run(2'b00, C_H0F2, 4'd2, 16'd0);
    tick_n(5);
    digital_in = 8'h00;
    tick_n(5);
    digital_in = 8'h04;
    tick_n(5);
    digital_in = 8'h01;
    tick_n(2);
    check("t5b_notrig", status_triggered, 0);
    check("t5b_busy", status_busy, 1);
    wait_done("t5b_done_cyc", 31);
    rd_chk("t5b_rd2", 4'd2, 8'h01);
    rd_chk("t5b_rd1", 4'd1, 8'h04);

    // reset during POST, then a clean run
    digital_in = 8'h80;
    start_run(2'b00, C_DC, 4'd4, 16'd0);
    tick_n(8);
    check("t6_post_trig", status_triggered, 1);
    rst = 1'b1;
    tick_n(1);
    check("t6_rst_status",
          {status_busy, status_triggered, status_done}, 0);
    check("t6_rst_rdv", rd_valid, 0);
    rst = 1'b0;
    start_run(2'b00, C_DC, 4'd4, 16'd0);
    wait_done("t6_done_cyc", 16);
    check("t6_trig", status_triggered, 1);
    rd_chk("t6_rd4", 4'd4, 8'h80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
